// File: rtl/pueo_cmdproc_pkg.sv
// Shared constants and FSM state type for the PUEO mode1 command processor.
package pueo_cmdproc_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam int         PKT_LEN  = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DISCARD = 2'd2
  } state_t;

endpackage

// File: rtl/pueo_sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
module pueo_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pueo_mode1_cmdproc.sv
// Mode1 command packet parser: 9-byte WRITE packets become register-write requests.
// Packet/error statistics counters are built only when PUEO_CMDPROC_STATS_EN is defined.
module pueo_mode1_cmdproc #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        sysclk_i,
  input  logic        sysrst_n_i,
  input  logic        cmd_rst_i,
  input  logic [7:0]  cmd_tdata_i,
  input  logic        cmd_tvalid_i,
  input  logic        cmd_tlast_i,
  output logic        req_valid_o,
  output logic [23:0] req_addr_o,
  output logic [31:0] req_data_o,
  input  logic        req_ready_i,
  output logic        err_o,
  output logic [15:0] cnt_good_o,
  output logic [15:0] cnt_err_o
);

  import pueo_cmdproc_pkg::*;

  localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST = 4'(PKT_LEN - 1);

  state_t        state, state_next;
  logic [3:0]    idx, idx_next;
  logic [7:0]    sum, sum_next, sum_final;
  logic [63:0]   sh, sh_next;
  logic [TW-1:0] timer, timer_next;
  logic          err_next, load_req, busy;

  // A pending request that is not being accepted this cycle blocks a new load.
  assign busy = req_valid_o && !req_ready_i;

  always_comb begin
    state_next = state;
    idx_next   = idx;
    sum_next   = sum;
    sh_next    = sh;
    timer_next = timer;
    err_next   = 1'b0;
    load_req   = 1'b0;
    sum_final  = sum + cmd_tdata_i;

    if (cmd_rst_i) begin
      state_next = IDLE;
      idx_next   = '0;
      sum_next   = '0;
      timer_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_tvalid_i) begin
            timer_next = '0;
            sh_next    = {sh[55:0], cmd_tdata_i};
            if (cmd_tlast_i) begin
              err_next = 1'b1;
            end else begin
              idx_next   = 4'd1;
              sum_next   = cmd_tdata_i;
              state_next = COLLECT;
            end
          end
        end

        COLLECT: begin
          if (cmd_tvalid_i) begin
            timer_next = '0;
            if (idx == LAST) begin
              // Checksum byte: opcode/addr/data already sit in sh, it is not shifted in.
              idx_next   = '0;
              sum_next   = '0;
              state_next = IDLE;
              if (!cmd_tlast_i) begin
                err_next   = 1'b1;
                state_next = DISCARD;
              end else if ((sum_final != 8'h00) || (sh[63:56] != OP_WRITE) || busy) begin
                err_next = 1'b1;
              end else begin
                load_req = 1'b1;
              end
            end else if (cmd_tlast_i) begin
              err_next   = 1'b1;
              idx_next   = '0;
              sum_next   = '0;
              state_next = IDLE;
            end else begin
              sh_next  = {sh[55:0], cmd_tdata_i};
              sum_next = sum_final;
              idx_next = idx + 4'd1;
            end
          end else if (timer == TLIM) begin
            err_next   = 1'b1;
            idx_next   = '0;
            sum_next   = '0;
            timer_next = '0;
            state_next = IDLE;
          end else begin
            timer_next = timer + 1'b1;
          end
        end

        DISCARD: begin
          if (cmd_tvalid_i && cmd_tlast_i) begin
            state_next = IDLE;
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
    if (!sysrst_n_i) begin
      state <= IDLE;
      idx   <= '0;
      sum   <= '0;
      sh    <= '0;
      timer <= '0;
      err_o <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      sum   <= sum_next;
      sh    <= sh_next;
      timer <= timer_next;
      err_o <= err_next;
    end
  end

  // A load in the same cycle as an acceptance wins, so back-to-back requests chain.
  always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
    if (!sysrst_n_i) begin
      req_valid_o <= 1'b0;
      req_addr_o  <= '0;
      req_data_o  <= '0;
    end else if (cmd_rst_i) begin
      req_valid_o <= 1'b0;
    end else if (load_req) begin
      req_valid_o <= 1'b1;
      req_addr_o  <= sh[55:32];
      req_data_o  <= sh[31:0];
    end else if (req_valid_o && req_ready_i) begin
      req_valid_o <= 1'b0;
    end
  end

`ifdef PUEO_CMDPROC_STATS_EN
  pueo_sat_counter #(.WIDTH(16)) u_cnt_good (
    .clk   (sysclk_i),
    .rst_n (sysrst_n_i),
    .clr   (1'b0),
    .inc   (load_req),
    .count (cnt_good_o)
  );

  pueo_sat_counter #(.WIDTH(16)) u_cnt_err (
    .clk   (sysclk_i),
    .rst_n (sysrst_n_i),
    .clr   (1'b0),
    .inc   (err_next),
    .count (cnt_err_o)
  );
`else
  assign cnt_good_o = 16'h0000;
  assign cnt_err_o  = 16'h0000;
`endif

endmodule
